// File: rtl/centroid_divider.sv
// Frame-end centroid: two lock-step restoring dividers turn the masked coordinate
// sums and the masked pixel count into a saturated (x_c, y_c), one quotient bit per clock.
module centroid_divider #(
    parameter int NUM_W = 28,
    parameter int DEN_W = 28,
    parameter int Q_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] sum_x,
    input  logic [NUM_W-1:0] sum_y,
    input  logic [DEN_W-1:0] count,
    output logic             busy,
    output logic             valid,
    output logic [Q_W-1:0]   x_c,
    output logic [Q_W-1:0]   y_c,
    output logic             div_zero
);

    typedef enum logic {IDLE, DIVIDE} state_t;

    localparam int             IT_W  = $clog2(NUM_W);
    localparam logic [Q_W-1:0] Q_MAX = '1;

    state_t           state;
    logic [IT_W-1:0]  iter;
    logic [DEN_W-1:0] den;
    // Numerator shifts out MSB-first while quotient bits shift in at the LSB,
    // so after NUM_W steps this register holds the full quotient.
    logic [NUM_W-1:0] num_x, num_y;
    logic [DEN_W:0]   rem_x, rem_y;

    logic             ge_x, ge_y;
    logic [DEN_W:0]   rem_x_next, rem_y_next;
    logic [NUM_W-1:0] quo_x_next, quo_y_next;

    function automatic logic [Q_W-1:0] saturate(input logic [NUM_W-1:0] q);
        return (|q[NUM_W-1:Q_W]) ? Q_MAX : q[Q_W-1:0];
    endfunction

    always_comb begin
        ge_x       = {rem_x, num_x[NUM_W-1]} >= {2'b00, den};
        ge_y       = {rem_y, num_y[NUM_W-1]} >= {2'b00, den};
        rem_x_next = (DEN_W+1)'({rem_x, num_x[NUM_W-1]} - (ge_x ? {2'b00, den} : '0));
        rem_y_next = (DEN_W+1)'({rem_y, num_y[NUM_W-1]} - (ge_y ? {2'b00, den} : '0));
        quo_x_next = {num_x[NUM_W-2:0], ge_x};
        quo_y_next = {num_y[NUM_W-2:0], ge_y};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the synchronous reset clears the datapath too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            x_c      <= '0;
            y_c      <= '0;
            div_zero <= 1'b0;
            iter     <= '0;
            den      <= '0;
            num_x    <= '0;
            num_y    <= '0;
            rem_x    <= '0;
            rem_y    <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_x <= sum_x;
                        num_y <= sum_y;
                        den   <= count;
                        rem_x <= '0;
                        rem_y <= '0;
                        iter  <= '0;
                        if (count == '0) begin
                            valid    <= 1'b1;
                            div_zero <= 1'b1;
                            x_c      <= '0;
                            y_c      <= '0;
                        end else begin
                            state <= DIVIDE;
                            busy  <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    rem_x <= rem_x_next;
                    rem_y <= rem_y_next;
                    num_x <= quo_x_next;
                    num_y <= quo_y_next;
                    if (iter == IT_W'(NUM_W - 1)) begin
                        x_c      <= saturate(quo_x_next);
                        y_c      <= saturate(quo_y_next);
                        div_zero <= 1'b0;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_divider.sv
// Directed bench for centroid_divider: latency, floor/saturation, divide-by-zero,
// ignored starts while busy, reset abort and reset/start collision.
module tb_centroid_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [27:0] sum_x, sum_y, count;
    logic        busy, valid, div_zero;
    logic [9:0]  x_c, y_c;

    int tests = 0;
    int fails = 0;
    int lat, bcnt, vcnt;

    centroid_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sum_x    (sum_x),
        .sum_y    (sum_y),
        .count    (count),
        .busy     (busy),
        .valid    (valid),
        .x_c      (x_c),
        .y_c      (y_c),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [27:0] sx, input logic [27:0] sy, input logic [27:0] c);
        sum_x = sx; sum_y = sy; count = c; start = 1'b1;
        tick();
        start = 1'b0;
        sum_x = 28'hABCDEF1; sum_y = 28'h1234567; count = 28'd3;
    endtask

    // Called in cycle 1 of a request; returns the cycle valid appears in and busy-cycle count.
    task automatic wait_valid(output int l, output int b);
        l = 1; b = 0;
        while (!valid && l < 100) begin
            if (busy) b++;
            tick();
            l++;
        end
    endtask

    task automatic divide(input string tag, input logic [27:0] sx, input logic [27:0] sy,
                          input logic [27:0] c, input logic [9:0] ex, input logic [9:0] ey);
        launch(sx, sy, c);
        wait_valid(lat, bcnt);
        check({tag, " latency"}, lat, 29);
        check({tag, " busy cycles"}, bcnt, 28);
        check({tag, " x_c"}, x_c, ex);
        check({tag, " y_c"}, y_c, ey);
        check({tag, " div_zero"}, div_zero, 0);
        check({tag, " busy at valid"}, busy, 0);
        tick();
        check({tag, " valid one cycle"}, valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sum_x = '0; sum_y = '0; count = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset valid", valid, 0);
        check("reset x_c", x_c, 0);
        check("reset y_c", y_c, 0);
        check("reset div_zero", div_zero, 0);

        divide("basic", 28'd1000, 28'd2000, 28'd10, 10'd100, 10'd200);
        divide("floor", 28'd7, 28'd9, 28'd2, 10'd3, 10'd4);
        divide("below/equal", 28'd5, 28'd6, 28'd6, 10'd0, 10'd1);
        divide("saturate", 28'h8000000, 28'd1023, 28'd1, 10'd1023, 10'd1023);
        divide("sat edge", 28'd1022, 28'd1024, 28'd1, 10'd1022, 10'd1023);

        // Divide by zero: immediate result, no busy.
        launch(28'd555, 28'd777, 28'd0);
        check("dz valid", valid, 1);
        check("dz div_zero", div_zero, 1);
        check("dz x_c", x_c, 0);
        check("dz y_c", y_c, 0);
        check("dz busy", busy, 0);
        tick();
        check("dz valid one cycle", valid, 0);
        check("dz held", div_zero, 1);
        divide("after dz", 28'd1000, 28'd2000, 28'd10, 10'd100, 10'd200);

        // Start in cycle 10 is ignored; start in cycle 29 is accepted.
        launch(28'd300, 28'd600, 28'd3);
        vcnt = 0;
        for (int c = 1; c < 10; c++) begin
            vcnt += int'(valid);
            tick();
        end
        sum_x = 28'd900; sum_y = 28'd900; count = 28'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 11; c < 29; c++) begin
            vcnt += int'(valid);
            tick();
        end
        check("b2b no early valid", vcnt, 0);
        check("b2b valid c29", valid, 1);
        check("b2b x_c", x_c, 100);
        check("b2b y_c", y_c, 200);
        launch(28'd50, 28'd70, 28'd5);
        check("b2b second busy", busy, 1);
        wait_valid(lat, bcnt);
        check("b2b second latency", lat, 29);
        check("b2b second x_c", x_c, 10);
        check("b2b second y_c", y_c, 14);
        tick();

        // Reset in cycle 15 aborts the division.
        launch(28'd1000, 28'd2000, 28'd10);
        for (int c = 1; c < 15; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort x_c", x_c, 0);
        check("abort y_c", y_c, 0);
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            vcnt += int'(valid);
            tick();
        end
        check("abort no valid", vcnt, 0);
        divide("after abort", 28'd7, 28'd9, 28'd2, 10'd3, 10'd4);

        // rst and start together: start is dropped.
        rst = 1'b1; sum_x = 28'd40; sum_y = 28'd40; count = 28'd4; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", busy, 0);
        vcnt = 0;
        for (int c = 0; c < 35; c++) begin
            vcnt += int'(valid);
            tick();
        end
        check("rst+start no valid", vcnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
